// File: rtl/axis_pkt_master_if.sv
// AXI-Stream beat bundle between the packet master and its downstream slave.
interface axis_pkt_master_if #(
  parameter int DATA_W = 8
);
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;

  modport master (
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_pkt_master.sv
// AXI-Stream packet source: incrementing byte pattern from seed, pkt_len beats, tlast on the last.
// Optional macro AXIS_PKT_MASTER_GAP_EN inserts one GAP state after every packet.
module axis_pkt_master #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_resetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  axis_pkt_master_if.master m_axis,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_cnt,
  output logic [1:0]        state_dbg
);

`ifdef AXIS_PKT_MASTER_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tvalid_q, tlast_q, busy_q, done_q;
  logic [15:0]       pkt_cnt_q;
  logic [LEN_W-1:0]  len_eff;
  logic              hs, last_hs;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
  // once tvalid rises it stays high with tdata/tlast frozen until that transfer happens.
  assign hs      = tvalid_q & m_axis.m_axis_tready;
  assign last_hs = hs & tlast_q;
  assign len_eff = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          rem_d   = len_eff;
          data_d  = seed;
        end
      end
      SEND: begin
        if (hs) begin
          data_d = data_q + DATA_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (tlast_q) begin
`ifdef AXIS_PKT_MASTER_GAP_EN
            state_d = GAP;
`else
            // Back-to-back: a request on the final handshake starts the next packet with no bubble.
            if (start) begin
              rem_d  = len_eff;
              data_d = seed;
            end else begin
              state_d = IDLE;
            end
`endif
          end
        end
      end
`ifdef AXIS_PKT_MASTER_GAP_EN
      GAP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge m_axis_clk or negedge m_axis_resetn) begin
    if (!m_axis_resetn) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      data_q    <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      tvalid_q <= (state_d == SEND);
      tlast_q  <= (state_d == SEND) && (rem_d == LEN_W'(1));
      busy_q   <= (state_d != IDLE);
      done_q   <= last_hs;
      if (last_hs) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
    end
  end

  assign m_axis.m_axis_tvalid = tvalid_q;
  assign m_axis.m_axis_tdata  = data_q;
  assign m_axis.m_axis_tlast  = tlast_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pkt_cnt              = pkt_cnt_q;
  assign state_dbg            = state_q;

  a_hold_under_backpressure: assert property (
    @(posedge m_axis_clk) disable iff (!m_axis_resetn)
    (tvalid_q && !m_axis.m_axis_tready) |=> (tvalid_q && $stable(data_q) && $stable(tlast_q))
  );

endmodule

// File: tb/tb_axis_pkt_master.sv
// Directed bench for axis_pkt_master: scoreboard queue of expected beats checked by a monitor.
module tb_axis_pkt_master;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

`ifdef AXIS_PKT_MASTER_GAP_EN
  localparam int HOLD    = 9;
  localparam int BUBBLES = 4;
`else
  localparam int HOLD    = 5;
  localparam int BUBBLES = 0;
`endif

  // ---- clock / reset ----
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              start;
  logic [LEN_W-1:0]  pkt_len;
  logic [DATA_W-1:0] seed;
  logic              busy, done;
  logic [15:0]       pkt_cnt;
  logic [1:0]        state_dbg;

  axis_pkt_master_if #(.DATA_W(DATA_W)) axis ();

  axis_pkt_master #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .m_axis_clk    (clk),
    .m_axis_resetn (rst_n),
    .start         (start),
    .pkt_len       (pkt_len),
    .seed          (seed),
    .m_axis        (axis),
    .busy          (busy),
    .done          (done),
    .pkt_cnt       (pkt_cnt),
    .state_dbg     (state_dbg)
  );

  // ---- scoreboard ----
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int exp_cnt = 0;
  logic [DATA_W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_pkt(input int len, input logic [DATA_W-1:0] sd);
    int n;
    logic [DATA_W-1:0] d;
    n = (len == 0) ? 1 : len;
    d = sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), d});
      d = d + 1'b1;
    end
  endtask

  // ---- monitor ----
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  logic              stall_last = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("stall_tvalid", 32'(axis.m_axis_tvalid), 32'd1);
        check("stall_tdata", 32'(axis.m_axis_tdata), 32'(stall_data));
        check("stall_tlast", 32'(axis.m_axis_tlast), 32'(stall_last));
      end
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none",
                   {axis.m_axis_tlast, axis.m_axis_tdata});
        end else begin
          check("beat_last_data", 32'({axis.m_axis_tlast, axis.m_axis_tdata}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      stall_q    <= axis.m_axis_tvalid & ~axis.m_axis_tready;
      stall_data <= axis.m_axis_tdata;
      stall_last <= axis.m_axis_tlast;
    end else begin
      stall_q <= 1'b0;
    end
  end

  // ---- driver tasks ----
  task automatic issue(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] sd);
    @(posedge clk); #1;
    start = 1'b1; pkt_len = len; seed = sd;
    push_pkt(int'(len), sd);
  endtask

  task automatic wait_done(input string name);
    int n;
    @(negedge clk);
    for (n = 0; n < 64; n++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  // ---- stimulus ----
  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
  int hs0, first, last, vcnt;

  initial begin
    start = 1'b0; pkt_len = '0; seed = '0; axis.m_axis_tready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(axis.m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(axis.m_axis_tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic 4-beat packet; late pkt_len/seed changes must not leak in.
    axis.m_axis_tready = 1'b1;
    issue(8'd4, 8'h10);
    @(posedge clk); #1;
    start = 1'b0; pkt_len = 8'hAA; seed = 8'h77;
    check("t1_latency_tvalid", 32'(axis.m_axis_tvalid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    exp_cnt++;
    wait_done("t1");

    // Backpressure with data wrap.
    hs0 = hs_cnt;
    issue(8'd3, 8'hFE);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      axis.m_axis_tready = pat[i][0];
    end
    exp_cnt++;
    wait_done("t2");
    check("t2_handshakes", 32'(hs_cnt - hs0), 32'd3);
    axis.m_axis_tready = 1'b1;

    // Zero length behaves as one beat.
    issue(8'd0, 8'h55);
    @(posedge clk); #1 start = 1'b0;
    check("t3_tlast_single", 32'(axis.m_axis_tlast), 32'd1);
    exp_cnt++;
    wait_done("t3");

    // start held high: back-to-back packets.
    hs0 = hs_cnt; first = -1; last = -1; vcnt = 0;
    issue(8'd2, 8'h20);
    push_pkt(2, 8'h20);
    push_pkt(2, 8'h20);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == HOLD) start = 1'b0;
      @(negedge clk);
      if (axis.m_axis_tvalid) begin
        if (first < 0) first = i;
        last = i;
        vcnt++;
      end
    end
    exp_cnt += 3;
    check("t4_valid_cycles", 32'(vcnt), 32'd6);
    check("t4_span", 32'(last - first + 1), 32'(6 + BUBBLES));
    check("t4_handshakes", 32'(hs_cnt - hs0), 32'd6);
    check("t4_pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // Asynchronous reset during beat 2 of 5.
    @(posedge clk); #1;
    start = 1'b1; pkt_len = 8'd5; seed = 8'h30;
    exp_q.push_back({1'b0, 8'h30});
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3;
    check("t5_pre_rst_tdata", 32'(axis.m_axis_tdata), 32'h31);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("t5_rst_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    check("t5_rst_tlast", 32'(axis.m_axis_tlast), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("t5_rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(8'd2, 8'h40);
    @(posedge clk); #1 start = 1'b0;
    exp_cnt++;
    wait_done("t5");

    // start pulse in the middle of a packet is ignored.
    issue(8'd4, 8'h60);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pkt_len = 8'd7; seed = 8'h99;
    @(posedge clk); #1 start = 1'b0;
    exp_cnt++;
    wait_done("t6");
    repeat (3) @(negedge clk);
    check("t6_idle_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
